palette_lut_banked: RTL and testbench
=====================================

Name: palette_lut_banked

Overview:
- Programmable, double-banked colour palette for the VGA pixel path. Turns an IDX_W-bit colour index into CH_W-bit R/G/B.
- Successor to the fixed 16-entry combinational decoder, with these additions:
  - run-time writable entries in NUM_BANKS banks;
  - bank swap applied only at frame boundaries;
  - per-frame brightness dimming;
  - a transparency flag;
  - a fixed 2-cycle registered pipeline.
- Sits between the sprite/background compositor and the VGA output registers.

Parameters:
- IDX_W, 4, colour index width. Entries per bank = 2**IDX_W.
- CH_W, 8, width of each colour channel.
- NUM_BANKS, 2, number of palette banks (minimum 2).
- TRANSP_IDX, 0, index reported as transparent.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  a pixel index is presented this cycle
- pix_idx  in  IDX_W  pixel colour index
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- bank_req  in  clog2(NUM_BANKS)  requested active bank
- dim_req  in  3  requested dim shift amount (0..7)
- wr_en  in  1  palette write strobe
- wr_bank  in  clog2(NUM_BANKS)  bank to write
- wr_addr  in  IDX_W  entry to write
- wr_rgb  in  3*CH_W  data to write, packed {R,G,B}
- out_valid  out  1  the RGB outputs are valid
- VGA_R, VGA_G, VGA_B  out  CH_W each  colour outputs
- transparent  out  1  the output pixel's index equals TRANSP_IDX

Behaviour:
- Reset (asynchronous, active-high):
  - all banks load DEFAULT_PALETTE (identical contents in every bank);
  - active_bank=0, active_dim=0;
  - out_valid=0, VGA_R/G/B=0, transparent=0;
  - pipeline valid bits are cleared.
- Stage 1 (edge N): register pix_valid, pix_idx, and a snapshot of active_bank and active_dim.
- Stage 2 (edge N+1):
  - read entry [snap_bank][idx];
  - right-shift each channel by snap_dim, zero-filling;
  - register VGA_R/G/B, out_valid and transparent.
- Latency and throughput:
  - latency is exactly 2 cycles from pix_valid to out_valid;
  - one pixel per cycle, no stalls, no backpressure.
- Bubbles: when a stage is invalid, out_valid=0 and VGA_R/G/B and transparent hold their last values.
- Frame-boundary update:
  - on the edge where frame_start=1, load active_bank<=bank_req and active_dim<=dim_req;
  - at all other times, bank_req and dim_req are ignored;
  - a pixel registered into stage 1 on that same edge uses the OLD bank and dim, so there is no tearing inside the pipeline.
- bank_req >= NUM_BANKS: the swap is ignored and active_bank keeps its value.
- Writes:
  - on the edge where wr_en=1, the entry [wr_bank][wr_addr] <= wr_rgb;
  - writes to the active bank are allowed;
  - wr_bank >= NUM_BANKS: the write is dropped.
- Read/write collision: if a stage-2 read hits the entry being written on the same edge, the output takes the OLD value (read-before-write). The new value is visible from the next lookup.
- frame_start and wr_en in the same cycle are independent; both take effect.
- Dim arithmetic: a shift of 7 on 0xFF gives 0x01. Shifting never wraps and never saturates upward.
- Storage: a flat register array (no inferred RAM, because of the reset-time init requirement). There are NUM_BANKS*2**IDX_W entries of 3*CH_W bits each.
- Reset mid-stream: outputs go to 0 immediately (asynchronous), the palette returns to defaults, and the first valid output appears 2 cycles after Reset deasserts and pix_valid=1.

Decomposition:
- Package palette_pkg:
  - DEFAULT_PALETTE, a 16 x 24-bit constant ({R,G,B}, index 0..15): 000000, 0C2658, 194C7F, 999966, E3E3F1, B6B6DA, 8ABCF7, 3278DE, FABC36, CCCCFF, 236AB2, F1EF07, F59200, CC7A00, F6E7D1, F7F9FD.
  - For IDX_W>4, entries above 15 reset to 000000. For IDX_W<4, the table is truncated.
  - An rgb_t packed struct {r,g,b} with width CH_W.
  - A function dim_rgb(rgb_t, shift).
- Sub-module palette_bank_store: the register array plus the write port and the combinational read port.
- The top level holds the pipeline and the frame-update registers.

Test Plan:
- Reset, then pix_idx=7 with pix_valid for one cycle -> 2 cycles later out_valid=1, RGB=32/78/DE, transparent=0. Idx 0 -> 00/00/00 with transparent=1.
- Write bank1 addr 7 = 123456; bank_req=1 without frame_start; lookup idx 7 -> still 3278DE. Then pulse frame_start and look up idx 7 -> 12/34/56.
- dim_req=2 with frame_start, then idx 15 -> 3D/3E/3F (F7>>2, F9>>2, FD>>2). dim_req=7 -> 01/01/01.
- Write bank0 addr 4 = ABCDEF on the same edge that stage 2 reads idx 4 -> E3E3F1. The next lookup -> AB/CD/EF.
- Stream idx 0..15 back-to-back with a pix_valid gap at idx 8 -> outputs match the default table 2 cycles delayed, out_valid=0 exactly in the gap cycle.
- Assert Reset mid-stream after writing bank0 addr 1 = FFFFFF -> outputs 0 immediately. After release, idx 1 -> 0C/26/58 and active_bank=0.

Source files
------------

// File: rtl/palette_lut_banked_pkg.sv
// Shared palette types and constants: the reset-time default table, the
// {r,g,b} pixel struct and the brightness-dim helper.
package palette_pkg;

   localparam int unsigned PAL_CH_W    = 8;
   localparam int unsigned DEF_ENTRIES = 16;

   typedef struct packed {
      logic [PAL_CH_W-1:0] r;
      logic [PAL_CH_W-1:0] g;
      logic [PAL_CH_W-1:0] b;
   } rgb_t;

   localparam logic [23:0] DEFAULT_PALETTE [DEF_ENTRIES] = '{
      24'h000000, 24'h0C2658, 24'h194C7F, 24'h999966,
      24'hE3E3F1, 24'hB6B6DA, 24'h8ABCF7, 24'h3278DE,
      24'hFABC36, 24'hCCCCFF, 24'h236AB2, 24'hF1EF07,
      24'hF59200, 24'hCC7A00, 24'hF6E7D1, 24'hF7F9FD
   };

   // Entries beyond the 16-entry table come up black.
   function automatic rgb_t default_entry(input int unsigned idx);
      rgb_t v;
      v = '0;
      if (idx < DEF_ENTRIES) v = rgb_t'(DEFAULT_PALETTE[idx[3:0]]);
      return v;
   endfunction

   function automatic rgb_t dim_rgb(input rgb_t c, input logic [2:0] shift);
      rgb_t v;
      v.r = c.r >> shift;
      v.g = c.g >> shift;
      v.b = c.b >> shift;
      return v;
   endfunction

endpackage

// File: rtl/palette_lut_banked_if.sv
// Pixel, control and palette-write signals between the compositor side and
// the palette lookup.
interface palette_lut_banked_if #(
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned CH_W      = 8,
   parameter int unsigned NUM_BANKS = 2
);
   localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic              pix_valid;
   logic [IDX_W-1:0]  pix_idx;
   logic              frame_start;
   logic [BANK_W-1:0] bank_req;
   logic [2:0]        dim_req;
   logic              wr_en;
   logic [BANK_W-1:0] wr_bank;
   logic [IDX_W-1:0]  wr_addr;
   logic [3*CH_W-1:0] wr_rgb;
   logic              out_valid;
   logic [CH_W-1:0]   VGA_R;
   logic [CH_W-1:0]   VGA_G;
   logic [CH_W-1:0]   VGA_B;
   logic              transparent;

   modport master (
      output pix_valid, pix_idx, frame_start, bank_req, dim_req,
             wr_en, wr_bank, wr_addr, wr_rgb,
      input  out_valid, VGA_R, VGA_G, VGA_B, transparent
   );

   modport slave (
      input  pix_valid, pix_idx, frame_start, bank_req, dim_req,
             wr_en, wr_bank, wr_addr, wr_rgb,
      output out_valid, VGA_R, VGA_G, VGA_B, transparent
   );

endinterface

// File: rtl/palette_lut_banked_bank_store.sv
// Flat register array holding every palette bank: one write port and one
// combinational read port. Registers (not RAM) so reset can load defaults.
module palette_bank_store
   import palette_pkg::*;
#(
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned BANK_W    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [BANK_W-1:0] i_wr_bank,
   input  logic [IDX_W-1:0]  i_wr_addr,
   input  rgb_t              i_wr_rgb,
   input  logic [BANK_W-1:0] i_rd_bank,
   input  logic [IDX_W-1:0]  i_rd_addr,
   output rgb_t              o_rd_rgb
);

   localparam int unsigned     ENTRIES = 2**IDX_W;
   localparam logic [BANK_W:0] BANKS   = (BANK_W+1)'(NUM_BANKS);

   rgb_t r_mem [NUM_BANKS][ENTRIES];
   logic w_wr_ok;

   assign w_wr_ok = i_wr_en && ({1'b0, i_wr_bank} < BANKS);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
               r_mem[b[BANK_W-1:0]][e[IDX_W-1:0]] <= default_entry(e);
            end
         end
      end else if (w_wr_ok) begin
         r_mem[i_wr_bank][i_wr_addr] <= i_wr_rgb;
      end
   end

   // Combinational read sees the pre-write contents on a same-edge collision.
   assign o_rd_rgb = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/palette_lut_banked.sv
// Double-banked programmable palette: two-stage registered lookup with
// frame-synchronous bank swap and brightness dimming.
module palette_lut_banked
   import palette_pkg::*;
#(
   parameter int unsigned IDX_W      = 4,
   parameter int unsigned CH_W       = 8,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned TRANSP_IDX = 0
) (
   input logic                 Clk,
   input logic                 Reset,
   palette_lut_banked_if.slave bus
);

   localparam int unsigned      BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [BANK_W:0]  BANKS  = (BANK_W+1)'(NUM_BANKS);
   localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

   logic [BANK_W-1:0] r_active_bank;
   logic [2:0]        r_active_dim;
   logic              r_s1_valid;
   logic [IDX_W-1:0]  r_s1_idx;
   logic [BANK_W-1:0] r_s1_bank;
   logic [2:0]        r_s1_dim;
   logic              r_out_valid;
   rgb_t              r_out_rgb;
   logic              r_transparent;
   rgb_t              w_rd_rgb;
   rgb_t              w_wr_rgb;
   logic              w_bank_ok;

   assign w_wr_rgb  = rgb_t'(bus.wr_rgb);
   assign w_bank_ok = {1'b0, bus.bank_req} < BANKS;

   palette_bank_store #(
      .IDX_W    (IDX_W),
      .NUM_BANKS(NUM_BANKS),
      .BANK_W   (BANK_W)
   ) u_store (
      .i_clk    (Clk),
      .i_rst    (Reset),
      .i_wr_en  (bus.wr_en),
      .i_wr_bank(bus.wr_bank),
      .i_wr_addr(bus.wr_addr),
      .i_wr_rgb (w_wr_rgb),
      .i_rd_bank(r_s1_bank),
      .i_rd_addr(r_s1_idx),
      .o_rd_rgb (w_rd_rgb)
   );

   // Stage 1 snapshots the active bank/dim before a same-edge frame update.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_active_bank <= '0;
         r_active_dim  <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_idx      <= '0;
         r_s1_bank     <= '0;
         r_s1_dim      <= '0;
      end else begin
         r_s1_valid <= bus.pix_valid;
         r_s1_idx   <= bus.pix_idx;
         r_s1_bank  <= r_active_bank;
         r_s1_dim   <= r_active_dim;
         if (bus.frame_start) begin
            if (w_bank_ok) r_active_bank <= bus.bank_req;
            r_active_dim <= bus.dim_req;
         end
      end
   end

   // Stage 2 holds colour and transparency through bubbles.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_out_valid   <= 1'b0;
         r_out_rgb     <= '0;
         r_transparent <= 1'b0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_rgb     <= dim_rgb(w_rd_rgb, r_s1_dim);
            r_transparent <= (r_s1_idx == TRANSP);
         end
      end
   end

   assign bus.out_valid   = r_out_valid;
   assign bus.VGA_R       = r_out_rgb.r;
   assign bus.VGA_G       = r_out_rgb.g;
   assign bus.VGA_B       = r_out_rgb.b;
   assign bus.transparent = r_transparent;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Self-checking bench for palette_lut_banked: table lookups, directed corner
// sequences and a random phase against a cycle-level reference model.
module tb_palette_lut_banked;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   palette_lut_banked_if #(.IDX_W(4), .CH_W(8), .NUM_BANKS(2)) bus ();

   palette_lut_banked #(
      .IDX_W     (4),
      .CH_W      (8),
      .NUM_BANKS (2),
      .TRANSP_IDX(0)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (bus)
   );

   typedef struct {
      int          idx;
      logic [23:0] rgb;
      logic        t;
   } vec_t;

   vec_t vecs [16];

   logic [23:0] m_pal [2][16];
   int          m_bank, m_dim;
   logic        m_s1_v;
   int          m_s1_idx, m_s1_bank, m_s1_dim;
   logic        m_ov;
   logic [23:0] m_rgb;
   logic        m_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] dimf(input logic [23:0] c, input int d);
      int r, g, b;
      r = int'(c[23:16]) / (1 << d);
      g = int'(c[15:8])  / (1 << d);
      b = int'(c[7:0])   / (1 << d);
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 16; i++) m_pal[b][i] = vecs[i].rgb;
      m_bank = 0; m_dim = 0;
      m_s1_v = 1'b0; m_s1_idx = 0; m_s1_bank = 0; m_s1_dim = 0;
      m_ov = 1'b0; m_rgb = '0; m_t = 1'b0;
   endtask

   task automatic drive_idle();
      bus.pix_valid = 0; bus.pix_idx = '0; bus.frame_start = 0; bus.bank_req = '0;
      bus.dim_req = '0; bus.wr_en = 0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_rgb = '0;
   endtask

   // One clock: drive inputs, advance the model, then compare all outputs.
   task automatic cycle(input logic pv, input int idx, input logic fs, input int breq,
                        input int dreq, input logic we, input int wb, input int wa,
                        input logic [23:0] wd);
      bus.pix_valid = pv; bus.pix_idx = 4'(idx); bus.frame_start = fs;
      bus.bank_req = 1'(breq); bus.dim_req = 3'(dreq); bus.wr_en = we;
      bus.wr_bank = 1'(wb); bus.wr_addr = 4'(wa); bus.wr_rgb = wd;
      m_ov = m_s1_v;
      if (m_s1_v) begin
         m_rgb = dimf(m_pal[m_s1_bank][m_s1_idx], m_s1_dim);
         m_t   = (m_s1_idx == 0);
      end
      if (we && wb < 2) m_pal[wb][wa] = wd;
      m_s1_v = pv; m_s1_idx = idx; m_s1_bank = m_bank; m_s1_dim = m_dim;
      if (fs) begin
         if (breq < 2) m_bank = breq;
         m_dim = dreq;
      end
      @(posedge clk); #1;
      check("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("model_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, m_rgb});
      check("model_transparent", 32'(bus.transparent), 32'(m_t));
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0);
   endtask

   task automatic lookup(input int idx);
      cycle(1, idx, 0, 0, 0, 0, 0, 0, 24'h0);
      idle();
   endtask

   task automatic expect_rgb(input string name, input logic [23:0] exp);
      check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check(name, {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, exp});
   endtask

   initial begin
      logic [23:0] defs [16];
      defs = '{24'h000000, 24'h0C2658, 24'h194C7F, 24'h999966,
               24'hE3E3F1, 24'hB6B6DA, 24'h8ABCF7, 24'h3278DE,
               24'hFABC36, 24'hCCCCFF, 24'h236AB2, 24'hF1EF07,
               24'hF59200, 24'hCC7A00, 24'hF6E7D1, 24'hF7F9FD};
      for (int i = 0; i < 16; i++) begin
         vecs[i].idx = i;
         vecs[i].rgb = defs[i];
         vecs[i].t   = (i == 0);
      end

      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
      check("reset_transparent", 32'(bus.transparent), 32'd0);
      model_reset();
      rst = 1'b0;

      // Default table, one isolated lookup per entry.
      for (int i = 0; i < 16; i++) begin
         lookup(vecs[i].idx);
         expect_rgb("table_rgb", vecs[i].rgb);
         check("table_transparent", 32'(bus.transparent), 32'(vecs[i].t));
      end

      // Back-to-back stream with a one-cycle bubble in place of idx 8.
      for (int k = 0; k <= 17; k++) begin
         int pix;
         if (k <= 16 && k != 8) cycle(1, (k < 8) ? k : k - 1, 0, 0, 0, 0, 0, 0, 24'h0);
         else idle();
         if (k >= 1) begin
            pix = k - 1;
            if (pix == 8) check("stream_gap_valid", 32'(bus.out_valid), 32'd0);
            else expect_rgb("stream_rgb", vecs[(pix < 8) ? pix : pix - 1].rgb);
         end
      end

      // Bank request without frame_start is ignored; swap takes effect on it.
      cycle(0, 0, 0, 1, 0, 1, 1, 7, 24'h123456);
      lookup(7);
      expect_rgb("bank_no_swap", 24'h3278DE);
      cycle(0, 0, 1, 1, 0, 0, 0, 0, 24'h0);
      lookup(7);
      expect_rgb("bank_swapped", 24'h123456);
      cycle(0, 0, 1, 0, 0, 0, 0, 0, 24'h0);

      // Write colliding with the stage-2 read returns the old entry.
      cycle(1, 4, 0, 0, 0, 0, 0, 0, 24'h0);
      cycle(0, 0, 0, 0, 0, 1, 0, 4, 24'hABCDEF);
      expect_rgb("collision_old", 24'hE3E3F1);
      lookup(4);
      expect_rgb("collision_new", 24'hABCDEF);

      // Dimming, including a pixel entering on the frame_start edge.
      cycle(0, 0, 1, 0, 2, 0, 0, 0, 24'h0);
      lookup(15);
      expect_rgb("dim2", 24'h3D3E3F);
      cycle(0, 0, 1, 0, 7, 0, 0, 0, 24'h0);
      lookup(15);
      expect_rgb("dim7", 24'h010101);
      cycle(1, 15, 1, 0, 0, 0, 0, 0, 24'h0);
      idle();
      expect_rgb("dim_old_on_frame_edge", 24'h010101);
      lookup(15);
      expect_rgb("dim0_restored", 24'hF7F9FD);

      // Reset mid-stream restores defaults and bank 0.
      cycle(0, 0, 1, 1, 0, 1, 0, 1, 24'hFFFFFF);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 24'h0);
      cycle(1, 3, 0, 0, 0, 0, 0, 0, 24'h0);
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      drive_idle();
      #2 rst = 1'b1;
      #1;
      check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      check("midreset_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
      check("midreset_transparent", 32'(bus.transparent), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      lookup(1);
      expect_rgb("after_reset_idx1", 24'h0C2658);
      cycle(0, 0, 0, 0, 0, 1, 1, 7, 24'h111111);
      lookup(7);
      expect_rgb("after_reset_bank0", 24'h3278DE);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         cycle(($urandom_range(3) != 0), $urandom_range(15),
               ($urandom_range(15) == 0), $urandom_range(1), $urandom_range(7),
               ($urandom_range(3) == 0), $urandom_range(1), $urandom_range(15),
               24'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
